// File: rtl/midi_transmitter.sv
// MIDI note-message serializer: one note_change_t in, two or three bytes of 8N1 serial out.
// With running status the status byte is dropped when it repeats the previous message's.
package midi_pkg;
  typedef enum logic {NOTE_OFF = 1'b0, NOTE_ON = 1'b1} note_status_t;

  typedef struct packed {
    note_status_t status;
    logic [7:0]   note_number;
    logic [7:0]   velocity;
  } note_change_t;
endpackage

module midi_transmitter
  import midi_pkg::*;
#(
  parameter int         CLOCK_HZ       = 50_000_000,
  parameter int         BAUD           = 31_250,
  parameter logic [3:0] CHANNEL        = 4'd0,
  parameter int         RUNNING_STATUS = 1
) (
  input  logic         clock_50_000_000,
  input  logic         reset_l,
  input  note_change_t note,
  input  logic         note_valid,
  output logic         note_ready,
  output logic         tx,
  output logic         busy
);
  localparam int BIT_CYCLES = CLOCK_HZ / BAUD;
  localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cycle_cnt;
  logic [2:0]       bit_idx;
  logic [1:0]       byte_idx;
  note_change_t     note_q;
  logic [7:0]       last_status;
  logic             last_status_valid;
  logic             armed;

  logic             accept;
  logic             bit_done;
  logic             skip_status;
  logic [7:0]       new_status;
  logic [7:0]       cur_byte;

  function automatic logic [7:0] status_byte(input note_status_t s);
    return {(s == NOTE_ON) ? 4'h9 : 4'h8, CHANNEL};
  endfunction

  assign accept      = note_valid && note_ready;
  assign bit_done    = (cycle_cnt == BIT_LAST);
  assign new_status  = status_byte(note.status);
  assign skip_status = (RUNNING_STATUS != 0) && last_status_valid && (last_status == new_status);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_50_000_000) begin
    if (!reset_l) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = START;
      START:   if (bit_done) state_next = DATA;
      DATA:    if (bit_done && bit_idx == 3'd7) state_next = STOP;
      STOP:    if (bit_done) state_next = (byte_idx == 2'd2) ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx         = 1'b1;
    busy       = 1'b1;
    note_ready = 1'b0;
    case (state)
      IDLE: begin
        busy       = 1'b0;
        note_ready = armed;
      end
      START:   tx = 1'b0;
      DATA:    tx = cur_byte[bit_idx];
      default: tx = 1'b1;
    endcase
  end

  // Byte index 0 is the status byte; a running-status message starts at index 1.
  always_comb begin
    cur_byte = 8'h00;
    case (byte_idx)
      2'd0:    cur_byte = status_byte(note_q.status);
      2'd1:    cur_byte = note_q.note_number & 8'h7F;
      default: cur_byte = note_q.velocity & 8'h7F;
    endcase
  end

  always_ff @(posedge clock_50_000_000) begin
    if (!reset_l) begin
      cycle_cnt         <= '0;
      bit_idx           <= '0;
      byte_idx          <= '0;
      last_status       <= '0;
      last_status_valid <= 1'b0;
      armed             <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (state == IDLE) begin
        cycle_cnt <= '0;
        bit_idx   <= '0;
        if (accept) begin
          byte_idx          <= skip_status ? 2'd1 : 2'd0;
          last_status       <= new_status;
          last_status_valid <= 1'b1;
        end
      end else begin
        cycle_cnt <= bit_done ? '0 : cycle_cnt + 1'b1;
        if (bit_done && state == DATA) bit_idx <= bit_idx + 1'b1;
        if (bit_done && state == STOP) byte_idx <= byte_idx + 1'b1;
      end
    end
  end

  // NOTE: the message register needs no reset; it is only read after an accept has loaded it.
  always_ff @(posedge clock_50_000_000) begin
    if (accept) note_q <= note;
  end

endmodule
